// File: rtl/riscv_immext_pipe.sv
// RISC-V immediate extractor with a 2-entry valid/ready skid FIFO.
// The immediate is decoded when a beat is accepted, and each entry stores {imm, tag, err}.
module riscv_immext_pipe #(
  parameter int XLEN = 32,
  parameter int TAGW = 32
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic            i_flush,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [31:0]     i_imm_instr,
  input  logic [2:0]      i_imm_src,
  input  logic [TAGW-1:0] i_tag,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_imm_ext,
  output logic [TAGW-1:0] o_tag,
  output logic            o_imm_err,
  output logic [7:0]      o_err_cnt
);

  localparam logic [2:0] SRC_I  = 3'd0;
  localparam logic [2:0] SRC_S  = 3'd1;
  localparam logic [2:0] SRC_B  = 3'd2;
  localparam logic [2:0] SRC_U  = 3'd3;
  localparam logic [2:0] SRC_J  = 3'd4;
  localparam logic [2:0] SRC_Z  = 3'd5;
  localparam logic [2:0] SRC_SH = 3'd6;

  logic [63:0]     imm_full;
  logic [XLEN-1:0] imm_new;
  logic            err_new;

  logic [XLEN-1:0] imm_q [2];
  logic [XLEN-1:0] imm_d [2];
  logic [TAGW-1:0] tag_q [2];
  logic [TAGW-1:0] tag_d [2];
  logic            err_q [2];
  logic            err_d [2];

  logic [1:0]      count_q, count_d;
  logic            wr_ptr_q, wr_ptr_d;
  logic            rd_ptr_q, rd_ptr_d;
  logic [7:0]      err_cnt_q, err_cnt_d;
  logic [XLEN-1:0] hold_imm_q, hold_imm_d;
  logic [TAGW-1:0] hold_tag_q, hold_tag_d;
  logic            hold_err_q, hold_err_d;

  logic            push;
  logic            pop;
  logic            unused_ok;

  // Decode into 64 bits, sign-extended from bit 31, then keep the low XLEN bits.
  always_comb begin
    imm_full = '0;
    err_new  = 1'b0;
    case (i_imm_src)
      SRC_I:  imm_full = {{52{i_imm_instr[31]}}, i_imm_instr[31:20]};
      SRC_S:  imm_full = {{52{i_imm_instr[31]}}, i_imm_instr[31:25], i_imm_instr[11:7]};
      SRC_B:  imm_full = {{52{i_imm_instr[31]}}, i_imm_instr[7], i_imm_instr[30:25],
                          i_imm_instr[11:8], 1'b0};
      SRC_U:  imm_full = {{32{i_imm_instr[31]}}, i_imm_instr[31:12], 12'b0};
      SRC_J:  imm_full = {{44{i_imm_instr[31]}}, i_imm_instr[19:12], i_imm_instr[20],
                          i_imm_instr[30:21], 1'b0};
      SRC_Z:  imm_full = {59'b0, i_imm_instr[19:15]};
      SRC_SH: imm_full = (XLEN == 64) ? {58'b0, i_imm_instr[25:20]}
                                      : {59'b0, i_imm_instr[24:20]};
      default: begin
        imm_full = '0;
        err_new  = 1'b1;
      end
    endcase
    imm_new = imm_full[XLEN-1:0];
  end

  assign unused_ok = ^{i_imm_instr[6:0], imm_full};

  assign o_ready = (count_q != 2'd2);
  assign o_valid = (count_q != 2'd0);
  assign push    = i_valid && o_ready && !i_flush;
  assign pop     = o_valid && i_ready && !i_flush;

  // When the FIFO is empty, the outputs replay the last head instead of showing a stale slot.
  assign o_imm_ext = o_valid ? imm_q[rd_ptr_q] : hold_imm_q;
  assign o_tag     = o_valid ? tag_q[rd_ptr_q] : hold_tag_q;
  assign o_imm_err = o_valid ? err_q[rd_ptr_q] : hold_err_q;
  assign o_err_cnt = err_cnt_q;

  always_comb begin
    imm_d      = imm_q;
    tag_d      = tag_q;
    err_d      = err_q;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    err_cnt_d  = err_cnt_q;
    hold_imm_d = o_imm_ext;
    hold_tag_d = o_tag;
    hold_err_d = o_imm_err;

    if (push) begin
      imm_d[wr_ptr_q] = imm_new;
      tag_d[wr_ptr_q] = i_tag;
      err_d[wr_ptr_q] = err_new;
      wr_ptr_d        = ~wr_ptr_q;
      if (err_new && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;

    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    if (i_flush) begin
      count_d  = 2'd0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      for (int i = 0; i < 2; i++) begin
        imm_q[i] <= '0;
        tag_q[i] <= '0;
        err_q[i] <= 1'b0;
      end
      count_q    <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      err_cnt_q  <= 8'd0;
      hold_imm_q <= '0;
      hold_tag_q <= '0;
      hold_err_q <= 1'b0;
    end else begin
      imm_q      <= imm_d;
      tag_q      <= tag_d;
      err_q      <= err_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      err_cnt_q  <= err_cnt_d;
      hold_imm_q <= hold_imm_d;
      hold_tag_q <= hold_tag_d;
      hold_err_q <= hold_err_d;
    end
  end

endmodule

// File: doc/riscv_immext_pipe.md
RISCV_IMMEXT_PIPE -- requirements
Module: riscv_immext_pipe

Interface
REQ-001 Parameter XLEN, default 32, sets the datapath width; the only legal values are 32 and 64.
REQ-002 Parameter TAGW, default 32, sets the width of the sideband tag (typically the PC) carried with each beat.
REQ-003 Port i_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port i_rstn, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port i_flush, input, 1 bit: synchronous discard of all buffered beats.
REQ-006 Port i_valid, input, 1 bit: an upstream beat is present.
REQ-007 Port o_ready, output, 1 bit: this block can accept a beat.
REQ-008 Port i_imm_instr, input, 32 bits: the instruction word.
REQ-009 Port i_imm_src, input, 3 bits: the immediate format selector.
REQ-010 Port i_tag, input, TAGW bits: the sideband tag, passed through unchanged.
REQ-011 Port o_valid, output, 1 bit: a downstream beat is present.
REQ-012 Port i_ready, input, 1 bit: downstream accepts the beat.
REQ-013 Port o_imm_ext, output, XLEN bits: the extended immediate.
REQ-014 Port o_tag, output, TAGW bits: the tag paired with o_imm_ext.
REQ-015 Port o_imm_err, output, 1 bit: the current output beat had an illegal selector.
REQ-016 Port o_err_cnt, output, 8 bits: saturating count of accepted illegal-selector beats.

Function
REQ-017 The selector encodings SHALL be: 0=I, 1=S, 2=B, 3=U, 4=J, 5=Z, 6=SH, 7=illegal.
REQ-018 The I, S, B and J formats SHALL follow standard RV32I bit placement, with B and J having bit0=0, sign-extended from instr[31] to XLEN.
REQ-019 The U format SHALL be {instr[31:12], 12'b0}, sign-extended from bit 31 when XLEN=64.
REQ-020 The Z format SHALL be instr[19:15] zero-extended (CSR uimm).
REQ-021 The SH format SHALL be instr[24:20] zero-extended for XLEN=32 and instr[25:20] zero-extended for XLEN=64.
REQ-022 For the illegal selector (7), the stored immediate SHALL be all zeros and the stored err bit SHALL be 1; for all other selectors the err bit SHALL be 0.
REQ-023 Extraction SHALL be performed at accept time; each buffer entry SHALL hold {imm, tag, err}.
REQ-024 The buffer SHALL be a 2-entry FIFO with an occupancy count of 0..2.
REQ-025 A push SHALL occur when i_valid && o_ready.
REQ-026 A pop SHALL occur when o_valid && i_ready.
REQ-027 o_ready SHALL equal (count < 2) and SHALL be derived from registered state only, with no combinational path from i_ready.
REQ-028 o_valid SHALL equal (count > 0); o_imm_ext, o_tag and o_imm_err SHALL present the head entry.
REQ-029 Latency SHALL be 1 cycle: a beat accepted at edge N is visible on the outputs after edge N when the buffer was empty.
REQ-030 Simultaneous push and pop with count=1 SHALL leave the count at 1, with the new beat becoming the head after the pop.
REQ-031 With count=2, o_ready SHALL be 0 and no push SHALL occur; a pop SHALL reduce the count to 1.
REQ-032 The head entry SHALL remain stable while o_valid && !i_ready (no drop, no reorder).
REQ-033 Ordering SHALL be strict FIFO; read and write pointers SHALL wrap modulo 2.
REQ-034 i_flush SHALL set count=0 on the next edge and override any push or pop in the same cycle; the incoming beat is dropped and o_err_cnt is not incremented for it.
REQ-035 o_err_cnt SHALL increment on each push with err=1, SHALL saturate at 255, and SHALL NOT be cleared by i_flush.
REQ-036 While o_valid=0, the data outputs are don't-care, but SHALL hold their last value (no X propagation from empty entries after reset).

Reset
REQ-037 Assertion of i_rstn=0 SHALL immediately force count=0, pointers=0, o_valid=0, o_ready=1, o_imm_ext=0, o_tag=0, o_imm_err=0 and o_err_cnt=0, including mid-transfer.
REQ-038 The first push SHALL be possible at the first rising edge after i_rstn deasserts.

Verification
REQ-039 XLEN=32, src=2, instr=0xFE000EE3, i_ready=1 -> after one edge, o_valid=1 and o_imm_ext=0xFFFFFFFC.
REQ-040 XLEN=64: src=0, instr=0xFFF00093 -> 0xFFFFFFFFFFFFFFFF; src=3, instr=0x123450B7 -> 0x0000000012345000; src=6, instr[25:20]=0x3F -> 0x3F.
REQ-041 XLEN=32, i_ready=0, three consecutive beats with i_valid=1 -> the first two are accepted and o_ready=0 on the third; then i_ready=1 -> both beats drain in order and o_ready returns to 1.
REQ-042 src=7 applied 300 times -> o_imm_ext=0 and o_imm_err=1 for each beat, and o_err_cnt saturates at 255.
REQ-043 count=2 with i_flush=1 and i_valid=1 in the same cycle -> after the edge, count=0, o_valid=0 and the new beat is absent.
REQ-044 Reset asserted asynchronously between edges with count=1 -> o_valid drops to 0 and o_ready rises to 1 without waiting for a clock edge.
